// File: rtl/i2c_pkg.sv
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared I2C constants: master/slave state encodings, R/W and
//                ACK/NACK bit values, and the slave FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package i2c_pkg;

  // Master FSM state encodings
  localparam logic [2:0] MASTER_STATE_IDLE  = 3'd0;
  localparam logic [2:0] MASTER_STATE_START = 3'd1;
  localparam logic [2:0] MASTER_STATE_ADDR  = 3'd2;
  localparam logic [2:0] MASTER_STATE_DATA  = 3'd3;
  localparam logic [2:0] MASTER_STATE_ACK   = 3'd4;
  localparam logic [2:0] MASTER_STATE_STOP  = 3'd5;

  // Slave FSM state encodings (visible on the state port)
  localparam logic [2:0] SLAVE_STATE_IDLE       = 3'd0;
  localparam logic [2:0] SLAVE_STATE_ADDRESSING = 3'd1;
  localparam logic [2:0] SLAVE_STATE_ACK_ADDR   = 3'd2;
  localparam logic [2:0] SLAVE_STATE_TRANSMIT   = 3'd3;
  localparam logic [2:0] SLAVE_STATE_RECEIVE    = 3'd4;
  localparam logic [2:0] SLAVE_STATE_ACK_DATA   = 3'd5;
  localparam logic [2:0] SLAVE_STATE_WAIT_MACK  = 3'd6;
  localparam logic [2:0] SLAVE_STATE_DONE       = 3'd7;

  localparam logic I2C_READ  = 1'b1;
  localparam logic I2C_WRITE = 1'b0;
  localparam logic ACK       = 1'b0;
  localparam logic NACK      = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE       = SLAVE_STATE_IDLE,
    ST_ADDRESSING = SLAVE_STATE_ADDRESSING,
    ST_ACK_ADDR   = SLAVE_STATE_ACK_ADDR,
    ST_TRANSMIT   = SLAVE_STATE_TRANSMIT,
    ST_RECEIVE    = SLAVE_STATE_RECEIVE,
    ST_ACK_DATA   = SLAVE_STATE_ACK_DATA,
    ST_WAIT_MACK  = SLAVE_STATE_WAIT_MACK,
    ST_DONE       = SLAVE_STATE_DONE
  } slave_state_e;

endpackage

`default_nettype wire

// File: rtl/i2c_sync_edge.sv
// ============================================================================
//  Module      : i2c_sync_edge
//  Description : Multi-flop synchroniser for an asynchronous bus pin with
//                registered rise/fall pulses. The level output is delayed one
//                extra flop so it stays aligned with the edge pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_sync_edge #(
  parameter int   STAGES    = 2,    // at least 2
  parameter logic RESET_VAL = 1'b1  // idle bus level
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_level;
  logic              r_rise;
  logic              r_fall;
  logic              w_sync_out;

  assign w_sync_out = r_sync[STAGES-1];

  // Synchronise the pin, then derive single-clk edge pulses from the settled value
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= {STAGES{RESET_VAL}};
      r_level <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[STAGES-2:0], i_pin};
      r_level <= w_sync_out;
      r_rise  <= w_sync_out & ~r_level;
      r_fall  <= ~w_sync_out & r_level;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

`default_nettype wire

// File: rtl/i2c_slave.sv
// ============================================================================
//  Module      : i2c_slave
//  Description : I2C target endpoint. Oversamples sclk/sda, detects START and
//                STOP, matches a 7-bit address, ACKs received bytes and
//                transmits data_in bytes until the master NACKs.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       sda_in,
  output logic       sda_out,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  output logic       tx_load,
  output logic       rw,
  output logic [2:0] state
);

  logic w_scl_lvl, w_scl_rise, w_scl_fall;
  logic w_sda_lvl, w_sda_rise, w_sda_fall;
  logic w_start, w_stop;
  logic [7:0] w_byte;

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_scl_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (sclk),
    .o_level (w_scl_lvl),
    .o_rise  (w_scl_rise),
    .o_fall  (w_scl_fall)
  );

  i2c_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sda_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (sda_in),
    .o_level (w_sda_lvl),
    .o_rise  (w_sda_rise),
    .o_fall  (w_sda_fall)
  );

  // sda only changes while sclk is high at bus conditions
  assign w_start = w_sda_fall & w_scl_lvl;
  assign w_stop  = w_sda_rise & w_scl_lvl;

  slave_state_e r_state, w_state_nxt;
  logic       r_sda,   w_sda_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [2:0] r_cnt,   w_cnt_nxt;
  logic [7:0] r_dout,  w_dout_nxt;
  logic       r_rxv,   w_rxv_nxt;
  logic       r_txl,   w_txl_nxt;
  logic       r_rw,    w_rw_nxt;
  // r_arm: in ACK states, set until the first fall starts the ACK drive;
  // in WAIT_MACK, set once the master has ACKed and a reload is due.
  logic       r_arm,   w_arm_nxt;

  // Byte as it stands after shifting in the currently sampled bit
  assign w_byte = {r_shift[6:0], w_sda_lvl};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sda   <= 1'b1;
      r_shift <= 8'h00;
      r_cnt   <= 3'd0;
      r_dout  <= 8'h00;
      r_rxv   <= 1'b0;
      r_txl   <= 1'b0;
      r_rw    <= 1'b0;
      r_arm   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sda   <= w_sda_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dout  <= w_dout_nxt;
      r_rxv   <= w_rxv_nxt;
      r_txl   <= w_txl_nxt;
      r_rw    <= w_rw_nxt;
      r_arm   <= w_arm_nxt;
    end
  end

  // Next-state and output logic; bus conditions win over bit handling
  always_comb begin
    w_state_nxt = r_state;
    w_sda_nxt   = r_sda;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    w_dout_nxt  = r_dout;
    w_rxv_nxt   = 1'b0;
    w_txl_nxt   = 1'b0;
    w_rw_nxt    = r_rw;
    w_arm_nxt   = r_arm;

    if (w_start) begin
      w_state_nxt = ST_ADDRESSING;
      w_cnt_nxt   = 3'd0;
      w_sda_nxt   = 1'b1;
      w_arm_nxt   = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
      w_sda_nxt   = 1'b1;
      w_arm_nxt   = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_sda_nxt = 1'b1;
        end

        ST_ADDRESSING: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = 3'(r_cnt + 3'd1);
            if (r_cnt == 3'd7) begin
              w_rw_nxt = w_byte[0];
              if (w_byte[7:1] == ADDRESS) begin
                w_state_nxt = ST_ACK_ADDR;
                w_arm_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_DONE;
              end
            end
          end
        end

        ST_ACK_ADDR: begin
          if (w_scl_fall) begin
            if (r_arm) begin
              w_sda_nxt = ACK;
              w_arm_nxt = 1'b0;
            end else if (r_rw == I2C_READ) begin
              w_state_nxt = ST_TRANSMIT;
              w_txl_nxt   = 1'b1;
              w_shift_nxt = data_in;
              w_sda_nxt   = data_in[7];
              w_cnt_nxt   = 3'd0;
            end else begin
              w_state_nxt = ST_RECEIVE;
              w_sda_nxt   = 1'b1;
              w_cnt_nxt   = 3'd0;
            end
          end
        end

        ST_TRANSMIT: begin
          if (w_scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_state_nxt = ST_WAIT_MACK;
              w_sda_nxt   = 1'b1;
              w_cnt_nxt   = 3'd0;
              w_arm_nxt   = 1'b0;
            end else begin
              w_shift_nxt = {r_shift[6:0], 1'b0};
              w_sda_nxt   = r_shift[6];
              w_cnt_nxt   = 3'(r_cnt + 3'd1);
            end
          end
        end

        ST_RECEIVE: begin
          if (w_scl_rise) begin
            w_shift_nxt = w_byte;
            w_cnt_nxt   = 3'(r_cnt + 3'd1);
            if (r_cnt == 3'd7) begin
              w_dout_nxt  = w_byte;
              w_rxv_nxt   = 1'b1;
              w_state_nxt = ST_ACK_DATA;
              w_arm_nxt   = 1'b1;
            end
          end
        end

        ST_ACK_DATA: begin
          if (w_scl_fall) begin
            if (r_arm) begin
              w_sda_nxt = ACK;
              w_arm_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_RECEIVE;
              w_sda_nxt   = 1'b1;
              w_cnt_nxt   = 3'd0;
            end
          end
        end

        ST_WAIT_MACK: begin
          if (w_scl_rise) begin
            if (w_sda_lvl == NACK) begin
              w_state_nxt = ST_DONE;
              w_sda_nxt   = 1'b1;
            end else begin
              w_arm_nxt = 1'b1;
            end
          end else if (w_scl_fall && r_arm) begin
            w_arm_nxt   = 1'b0;
            w_state_nxt = ST_TRANSMIT;
            w_txl_nxt   = 1'b1;
            w_shift_nxt = data_in;
            w_sda_nxt   = data_in[7];
            w_cnt_nxt   = 3'd0;
          end
        end

        ST_DONE: begin
          w_sda_nxt = 1'b1;
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_sda_nxt   = 1'b1;
        end
      endcase
    end
  end

  assign sda_out  = r_sda;
  assign data_out = r_dout;
  assign rx_valid = r_rxv;
  assign tx_load  = r_txl;
  assign rw       = r_rw;
  assign state    = r_state;

endmodule

`default_nettype wire

// File: tb/tb_i2c_slave.sv
// ============================================================================
//  Module      : tb_i2c_slave
//  Description : Bus-level bench for i2c_slave: a bit-banged master drives
//                sclk/sda; received and transmitted bytes are checked against
//                a queue of expected bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_i2c_slave;

  localparam int Q = 10;  // clks per quarter sclk period

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk;
  logic       m_sda;
  logic       sda_in;
  logic       sda_out;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       rx_valid;
  logic       tx_load;
  logic       rw;
  logic [2:0] state;

  int n_total = 0;
  int n_bad   = 0;
  int rx_cnt  = 0;
  int tx_cnt  = 0;
  bit sda_low_seen = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] txq[$];

  // Open-drain wired-AND of master and slave
  assign sda_in = m_sda & sda_out;

  i2c_slave #(.ADDRESS(7'h50), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .sclk     (sclk),
    .sda_in   (sda_in),
    .sda_out  (sda_out),
    .data_in  (data_in),
    .data_out (data_out),
    .rx_valid (rx_valid),
    .tx_load  (tx_load),
    .rw       (rw),
    .state    (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: scoreboard for received bytes and pulse counting
  always @(negedge clk) begin
    if (!rst) begin
      if (sda_out == 1'b0) sda_low_seen = 1'b1;
      if (tx_load) tx_cnt++;
      if (rx_valid) begin
        rx_cnt++;
        if (rxq.size() == 0) check("rx_unexpected_qsize", rxq.size(), 1);
        else check("rx_data", int'(data_out), int'(rxq.pop_front()));
      end
    end
  end

  task automatic bus_start();
    m_sda = 1'b1; sclk = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    sclk = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_rstart();
    m_sda = 1'b1; wait_clks(Q);
    sclk = 1'b1; wait_clks(Q);
    m_sda = 1'b0; wait_clks(Q);
    sclk = 1'b0; wait_clks(Q);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; wait_clks(Q);
    sclk = 1'b1; wait_clks(Q);
    m_sda = 1'b1; wait_clks(Q);
  endtask

  // One bit cycle from sclk low; returns the wire level mid-high
  task automatic bit_cycle(input logic b, output logic line);
    m_sda = b; wait_clks(Q);
    sclk = 1'b1; wait_clks(Q);
    line = sda_in;
    wait_clks(Q);
    sclk = 1'b0; wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic l;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], l);
    bit_cycle(1'b1, ack);
  endtask

  // Reads 8 bits, optionally changes data_in, then sends the master ACK/NACK
  task automatic read_byte(input logic mack, input logic [7:0] next_din);
    logic [7:0] got;
    logic l;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, l);
      got[i] = l;
    end
    data_in = next_din;
    bit_cycle(mack, l);
    if (txq.size() == 0) check("tx_unexpected_qsize", txq.size(), 1);
    else check("tx_byte", int'(got), int'(txq.pop_front()));
  endtask

  initial begin
    logic ack;
    logic l;
    int rx0, tx0;

    rst = 1'b1; sclk = 1'b1; m_sda = 1'b1; data_in = 8'h00;
    wait_clks(5);
    @(negedge clk) rst = 1'b0;
    wait_clks(5);

    // Reset state
    @(negedge clk);
    check("rst_state", state, 0);
    check("rst_sda", sda_out, 1);
    check("rst_dout", data_out, 0);
    check("rst_rxv", rx_valid, 0);
    check("rst_txl", tx_load, 0);
    check("rst_rw", rw, 0);

    // Write 0xA6 to 0x50
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("w1_addr_ack", ack, 0);
    check("w1_rw", rw, 0);
    rxq.push_back(8'hA6);
    write_byte(8'hA6, ack); check("w1_data_ack", ack, 0);
    bus_stop(); wait_clks(4);
    check("w1_state_idle", state, 0);
    check("w1_rx_pulses", rx_cnt - rx0, 1);

    // Read 0xF6 from 0x50, master NACKs
    tx0 = tx_cnt;
    data_in = 8'hF6;
    bus_start();
    write_byte(8'hA1, ack); check("r1_addr_ack", ack, 0);
    check("r1_rw", rw, 1);
    txq.push_back(8'hF6);
    read_byte(1'b1, 8'hF6);
    wait_clks(2);
    check("r1_state_done", state, 7);
    check("r1_tx_pulses", tx_cnt - tx0, 1);
    bus_stop(); wait_clks(4);
    check("r1_state_idle", state, 0);

    // Address mismatch 0x51: no drive, no pulses, DONE until STOP
    rx0 = rx_cnt; tx0 = tx_cnt;
    sda_low_seen = 1'b0;
    bus_start();
    write_byte(8'hA2, ack); check("mm_addr_nack", ack, 1);
    check("mm_state_done", state, 7);
    write_byte(8'h00, ack); check("mm_byte_nack", ack, 1);
    check("mm_state_still_done", state, 7);
    bus_stop(); wait_clks(4);
    check("mm_state_idle", state, 0);
    check("mm_sda_never_low", sda_low_seen, 0);
    check("mm_no_rx", rx_cnt - rx0, 0);
    check("mm_no_tx", tx_cnt - tx0, 0);

    // Two-byte write 0x12, 0x34
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("w2_addr_ack", ack, 0);
    rxq.push_back(8'h12);
    write_byte(8'h12, ack); check("w2_b0_ack", ack, 0);
    rxq.push_back(8'h34);
    write_byte(8'h34, ack); check("w2_b1_ack", ack, 0);
    bus_stop(); wait_clks(4);
    check("w2_rx_pulses", rx_cnt - rx0, 2);
    check("w2_dout_last", data_out, 8'h34);

    // Read two bytes, master ACKs the first, data_in changes before 9th fall
    tx0 = tx_cnt;
    data_in = 8'h5A;
    bus_start();
    write_byte(8'hA1, ack); check("r2_addr_ack", ack, 0);
    txq.push_back(8'h5A);
    txq.push_back(8'h3C);
    read_byte(1'b0, 8'h3C);
    read_byte(1'b1, 8'h3C);
    check("r2_tx_pulses", tx_cnt - tx0, 2);
    wait_clks(2);
    check("r2_state_done", state, 7);
    bus_stop(); wait_clks(4);

    // Repeated START after 4 data bits, then reset mid-TRANSMIT
    rx0 = rx_cnt;
    bus_start();
    write_byte(8'hA0, ack); check("rs_addr_ack", ack, 0);
    for (int i = 0; i < 4; i++) bit_cycle(1'b1, l);
    bus_rstart();
    wait_clks(2);
    check("rs_state_addr", state, 1);
    check("rs_no_rx", rx_cnt - rx0, 0);
    data_in = 8'h00;
    write_byte(8'hA1, ack); check("rs_addr2_ack", ack, 0);
    for (int i = 0; i < 3; i++) bit_cycle(1'b1, l);
    check("rs_in_transmit", state, 3);
    check("rs_sda_driven", sda_out, 0);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rst_mid_state", state, 0);
    check("rst_mid_sda", sda_out, 1);
    rst = 1'b0;
    m_sda = 1'b1; wait_clks(Q);
    sclk = 1'b1; wait_clks(Q);
    check("post_rst_idle", state, 0);

    check("rxq_empty", rxq.size(), 0);
    check("txq_empty", txq.size(), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Safety bound on total run time
  initial begin
    #2000000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) endpoint; the responder for the existing i2c master.
- Oversamples sclk/sda on the system clock, detects START/STOP, and matches a 7-bit address.
- For master-write transactions it receives bytes and ACKs each one. For master-read transactions it transmits bytes from data_in until the master NACKs.
- Sits on the same sclk/sda_in/sda_out split-pin bus as the master; open-drain is modelled as sda_out=1 meaning released.

Parameters:
- ADDRESS, 7'h50, 7-bit target address compared against the first byte.
- SYNC_STAGES, 2, synchroniser depth on sclk and sda_in (minimum 2).

Ports:
- clk  input  1  system clock; must run at ≥8× sclk frequency.
- rst  input  1  synchronous, active-high reset.
- sclk  input  1  bus clock from master.
- sda_in  input  1  bus data as seen on the wire.
- sda_out  output  1  slave data drive; 0 pulls low, 1 releases.
- data_in  input  8  byte to transmit; sampled on tx_load.
- data_out  output  8  last received byte.
- rx_valid  output  1  one-clk pulse when data_out is updated.
- tx_load  output  1  one-clk pulse when data_in is captured.
- rw  output  1  R/W bit of the current transaction (1 = master reads).
- state  output  3  current FSM state.

Behaviour:
- Reset (rst=1 at posedge clk): state=IDLE, sda_out=1, data_out=0, rx_valid=0, tx_load=0, rw=0, bit counter=0. Reset mid-transfer aborts immediately and releases sda.
- sclk and sda_in each pass through SYNC_STAGES flops. Edges are detected on the synchronised values, so edge flags assert SYNC_STAGES+1 clks after the pin change.
- START: sda falls while sclk is high. STOP: sda rises while sclk is high.
- Data bits: sampled on sclk rise. Slave drive: changes one clk after a detected sclk fall. All bytes are MSB first.
- STOP in any state -> IDLE, sda_out=1. START in any state, including a repeated start -> ADDRESSING, bit counter=0.
- STOP/START detection takes priority over bit sampling in the same clk.
- States (3-bit encoding):
  - 0 IDLE: sda_out=1; wait for START.
  - 1 ADDRESSING: shift 8 bits on sclk rises. After the 8th bit, compare [7:1] with ADDRESS and latch rw=[0]. Match -> ACK_ADDR at the next sclk fall. Mismatch -> DONE with sda untouched.
  - 2 ACK_ADDR: sda_out=0 from the sclk fall after bit 8 until the following sclk fall.
    - At that fall with rw=0 -> RECEIVE, sda_out=1.
    - At that fall with rw=1 -> TRANSMIT: pulse tx_load, capture data_in into the shift register, drive its MSB.
  - 3 TRANSMIT: drive the next bit on each sclk fall; after 8 bits, release sda (sda_out=1) and go to WAIT_MACK.
  - 4 RECEIVE: shift on sclk rises; after 8 bits, data_out<=shift, rx_valid pulses one clk, -> ACK_DATA.
  - 5 ACK_DATA: same drive timing as ACK_ADDR; at the releasing fall -> RECEIVE, counter=0. Unlimited bytes per transaction.
  - 6 WAIT_MACK: sample sda on sclk rise.
    - 0 (ACK): at the next fall, pulse tx_load, reload data_in, -> TRANSMIT.
    - 1 (NACK): -> DONE, sda_out=1.
  - 7 DONE: sda_out=1; ignore bits until STOP (-> IDLE) or START (-> ADDRESSING).
- Bit counter is 3 bits; the value 7 with a sampled bit marks the end of a byte.
- The slave never stretches sclk.
- Glitches shorter than SYNC_STAGES clks are not guaranteed to be filtered.

Decomposition:
- Shared package i2c_pkg:
  - 3-bit state localparams (SLAVE_STATE_IDLE..SLAVE_STATE_DONE), alongside the existing master state constants.
  - I2C_READ=1, I2C_WRITE=0.
  - ACK=0, NACK=1.
- Sub-module i2c_sync_edge:
  - Parameterised synchroniser plus rise/fall pulse generation.
  - Instantiated once for sclk and once for sda_in.
  - Keeps the FSM free of metastability logic.

Test Plan:
- Write 0xA6 to 0x50: address byte 0xA0 -> sda_out=0 across 9th sclk high; data_out=8'hA6 with a single rx_valid pulse; sda_out=0 on data 9th clock; STOP -> state=0.
- Read from 0x50 with data_in=8'hF6: address byte 0xA1 -> ACK; tx_load pulses once; sda_out sequence 1,1,1,1,0,1,1,0 on successive sclk highs; master NACK -> state=7; STOP -> state=0.
- Address mismatch, byte 0xA2 (addr 0x51): sda_out stays 1 for all 9 clocks; no rx_valid/tx_load; state=7 until STOP.
- Two-byte write 0x12, 0x34: two rx_valid pulses; data_out=8'h12 then 8'h34; both ACKed.
- Read with master ACK on byte 1, data_in changed to 8'h3C before 9th fall: second tx_load; second byte on sda_out=00111100.
- Repeated START mid-RECEIVE (after 4 bits) -> state=1, counter cleared, no rx_valid. Then rst=1 mid-TRANSMIT -> next clk state=0, sda_out=1.
